// File: rtl/iter_shift_ctrl_pkg.sv
// Shared definitions for the iterative shift unit controller.
//   op_e    : shift operation encodings driven by the ALU/control unit
//   state_e : controller FSM state encodings
package iter_shift_ctrl_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_BIG_STEP = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shift_ctrl_if.sv
// Request/response bundle between the ALU/control unit and the shift unit.
//   start : request strobe (master -> slave)
//   op    : shift operation (master -> slave)
//   shamt : shift amount, clog2(WIDTH) bits (master -> slave)
//   in    : operand (master -> slave)
//   busy  : unit is processing a request (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
//   out   : registered result (slave -> master)
interface iter_shift_ctrl_if
  import iter_shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int SW = $clog2(WIDTH);

  logic             start;
  op_e              op;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, op, shamt, in,
    input  busy, done, out
  );

  modport slave (
    input  start, op, shamt, in,
    output busy, done, out
  );

endinterface

// File: rtl/iter_shift_ctrl_shift_step.sv
// One step of the shift datapath: shifts/rotates acc by BIG_STEP (big=1)
// or by a single bit (big=0).
//   acc      : current accumulator value
//   op       : operation to apply
//   big      : 1 = step by BIG_STEP, 0 = step by 1
//   acc_next : shifted accumulator (combinational)
module shift_step
  import iter_shift_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int BIG_STEP = DEFAULT_BIG_STEP
) (
  input  logic [WIDTH-1:0] acc,
  input  op_e              op,
  input  logic             big,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] rol_one;
  logic [WIDTH-1:0] rol_big;

  // Rotation is pure wiring: bit gi takes the bit that sits 1 (or
  // BIG_STEP) positions below it, wrapping the MSBs into the LSBs.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rol
      assign rol_one[gi] = acc[(gi + WIDTH - 1) % WIDTH];
      assign rol_big[gi] = acc[(gi + WIDTH - BIG_STEP) % WIDTH];
    end
  endgenerate

  always_comb begin
    acc_next = acc;
    unique case (op)
      OP_SLL: acc_next = big ? (acc << BIG_STEP) : (acc << 1);
      OP_SRL: acc_next = big ? (acc >> BIG_STEP) : (acc >> 1);
      OP_SRA: acc_next = big ? WIDTH'($signed(acc) >>> BIG_STEP)
                             : WIDTH'($signed(acc) >>> 1);
      OP_ROL: acc_next = big ? rol_big : rol_one;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift unit controller. A request accepted in IDLE is executed
// by stepping the shift_step datapath (by BIG_STEP while the remaining
// amount allows, then by 1) until the remaining count reaches zero; the
// result is then presented on out with a one-cycle done pulse.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of iter_shift_ctrl_if (start/op/shamt/in in,
//           busy/done/out out)
module iter_shift_ctrl
  import iter_shift_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int BIG_STEP = DEFAULT_BIG_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  iter_shift_ctrl_if.slave    bus
);

  localparam int            SW  = $clog2(WIDTH);
  localparam logic [SW-1:0] BIG = SW'(BIG_STEP);
  localparam logic [SW-1:0] ONE = SW'(1);

  state_e           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] out_reg;
  logic [SW-1:0]    rem_reg;
  logic [SW-1:0]    rem_next;
  op_e              op_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             big_step;

  // Take the large step whenever enough shift amount remains; this gives
  // floor(shamt/BIG_STEP) + (shamt mod BIG_STEP) steps in total.
  assign big_step = (rem_reg >= BIG);
  assign rem_next = big_step ? (rem_reg - BIG) : (rem_reg - ONE);

  shift_step #(
    .WIDTH    (WIDTH),
    .BIG_STEP (BIG_STEP)
  ) u_shift_step (
    .acc      (acc_reg),
    .op       (op_reg),
    .big      (big_step),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      out_reg   <= '0;
      rem_reg   <= '0;
      op_reg    <= OP_SLL;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            acc_reg  <= bus.in;
            op_reg   <= bus.op;
            rem_reg  <= bus.shamt;
            busy_reg <= 1'b1;
            if (bus.shamt == '0) begin
              // Nothing to shift: the operand is the result.
              state_reg <= S_DONE;
              out_reg   <= bus.in;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_SHIFT;
            end
          end else begin
            busy_reg <= 1'b0;
          end
        end

        S_SHIFT: begin
          acc_reg <= acc_next;
          rem_reg <= rem_next;
          if (rem_next == '0) begin
            // Final step: publish the freshly shifted value directly so out
            // is valid in the same cycle done is raised.
            state_reg <= S_DONE;
            out_reg   <= acc_next;
            done_reg  <= 1'b1;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.out  = out_reg;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
module tb_iter_shift_ctrl;
  import iter_shift_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  iter_shift_ctrl_if #(.WIDTH(32)) bus ();

  iter_shift_ctrl #(
    .WIDTH    (32),
    .BIG_STEP (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] in;
    logic [31:0] exp_out;
    int          exp_steps;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: whole-amount shift with plain arithmetic.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input int sh, input logic [31:0] x);
    case (op)
      2'b00: return x << sh;
      2'b01: return x >> sh;
      2'b10: return 32'($signed(x) >>> sh);
      default: return (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
    endcase
  endfunction

  function automatic int ref_steps(input int sh);
    return sh / 4 + sh % 4;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] x,
                        output logic [31:0] res, output int lat, output int busy_cycles,
                        output bit pulse_ok, output logic [31:0] held);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_e'(op);
    bus.shamt = sh;
    bus.in    = x;
    @(posedge clk);
    #1;
    // Disturb the inputs after acceptance; they must not matter.
    bus.start = 1'b0;
    bus.in    = $urandom;
    bus.op    = op_e'(2'($urandom_range(0, 3)));
    bus.shamt = 5'($urandom);
    lat = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.out;
    if (bus.busy) busy_cycles++;
    @(posedge clk);
    #1;
    pulse_ok = !bus.done && !bus.busy;
    held = bus.out;
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] op, input logic [4:0] sh,
                               input logic [31:0] x, input logic [31:0] exp_out, input int exp_steps);
    logic [31:0] res;
    logic [31:0] held;
    int lat;
    int bc;
    bit pok;
    run_op(op, sh, x, res, lat, bc, pok, held);
    $display("txn %s op=%0d shamt=%0d in=0x%08h out=0x%08h lat=%0d busy=%0d", tag, op, sh, x, res, lat, bc);
    check({tag, "_out"}, res, exp_out);
    check({tag, "_latency"}, 32'(lat), 32'(exp_steps));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_steps + 1));
    check({tag, "_done_single"}, {31'd0, pok}, 32'd1);
    check({tag, "_out_held"}, held, exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc[2];
    logic [31:0] outs[2];
    int ndone;
    int spurious;

    checks = 0;
    failures = 0;
    bus.start = 1'b0;
    bus.op    = OP_SLL;
    bus.shamt = '0;
    bus.in    = '0;
    rst_n     = 1'b0;

    //            op     shamt  in            exp_out       steps
    vecs[0] = '{2'b00, 5'd5,  32'h00000001, 32'h00000020, 2};
    vecs[1] = '{2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 10};
    vecs[2] = '{2'b01, 5'd31, 32'h80000000, 32'h00000001, 10};
    vecs[3] = '{2'b11, 5'd4,  32'h80000001, 32'h00000018, 1};
    vecs[4] = '{2'b00, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[5] = '{2'b11, 5'd31, 32'h12345678, 32'h091A2B3C, 10};
    vecs[6] = '{2'b10, 5'd3,  32'h80000000, 32'hF0000000, 3};
    vecs[7] = '{2'b01, 5'd8,  32'h0000FF00, 32'h000000FF, 2};

    #2;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_out", bus.out, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].in,
                    vecs[i].exp_out, vecs[i].exp_steps);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [4:0]  sh;
      logic [31:0] x;
      op = 2'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      x  = $urandom;
      run_and_check($sformatf("rnd%0d", i), op, sh, x, ref_shift(op, int'(sh), x), ref_steps(int'(sh)));
    end

    // Back-to-back: start held high; only IDLE accepts, in is scrambled
    // whenever the unit is busy.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_SLL;
    bus.shamt = 5'd3;
    bus.in    = 32'h1;
    ndone = 0;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    outs[0] = '0;
    outs[1] = '0;
    for (int c = 0; c < 40 && ndone < 2; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cyc[ndone] = c;
        outs[ndone] = bus.out;
        ndone++;
      end
      bus.in = bus.busy ? $urandom : 32'h1;
    end
    bus.start = 1'b0;
    $display("txn b2b dones=%0d at %0d,%0d outs=0x%08h,0x%08h", ndone, done_cyc[0], done_cyc[1], outs[0], outs[1]);
    check("b2b_count", 32'(ndone), 32'd2);
    check("b2b_first_latency", 32'(done_cyc[0]), 32'd3);
    check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
    check("b2b_out0", outs[0], 32'h8);
    check("b2b_out1", outs[1], 32'h8);
    repeat (3) @(posedge clk);

    // Reset mid-operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_SLL;
    bus.shamt = 5'd31;
    bus.in    = 32'h1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("txn reset_mid busy=%0b done=%0b out=0x%08h", bus.busy, bus.done, bus.out);
    check("rst_async_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_async_done", {31'd0, bus.done}, 32'd0);
    check("rst_async_out", bus.out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) spurious++;
    end
    check("rst_no_done", 32'(spurious), 32'd0);
    run_and_check("post_rst", 2'b01, 5'd8, 32'h0000FF00, 32'h000000FF, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
